// File: rtl/fifo1_rd_pkg.sv
// fifo1_rd_pkg: shared types and defaults for the fifo1 read-side scheduler.
//   state_t  : scheduler state code (3-bit binary; the unused code 7 recovers to IDLE)
//   core_t   : state + settle/gap counter + event counter, voted as one word under TMR
package fifo1_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LATCH  = 3'd2,
    ST_START  = 3'd3,
    ST_RUN    = 3'd4,
    ST_NOSCA  = 3'd5,
    ST_GAP    = 3'd6
  } state_t;

  typedef struct packed {
    state_t      st;
    logic [2:0]  sg;   // shared settle/gap counter
    logic [11:0] evt;  // completed events, wraps
  } core_t;

  localparam core_t CORE_RST = '{st: ST_IDLE, sg: 3'd0, evt: 12'd0};

  localparam int DEF_SETTLE  = 2;
  localparam int DEF_GAP     = 2;
  localparam int DEF_TMO_W   = 10;
  localparam int DEF_TMO_MAX = 1000;

endpackage

// File: rtl/fifo1_rd_sched_tmo_cnt.sv
// tmo_cnt: clearable up-counter with terminal-count compare, optionally triplicated.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0
//   inc      : count up by one
//   tc       : count equals LIMIT
module tmo_cnt #(
  parameter int W     = 10,
  parameter int LIMIT = 999,
  parameter int TMR   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int N = (TMR != 0) ? 3 : 1;

  logic [W-1:0] cnt_r [N];
  logic [W-1:0] cnt_v;

  // Every copy reloads from the voted value so a single upset is scrubbed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst || clr) cnt_r[i] <= '0;
      else            cnt_r[i] <= inc ? cnt_v + W'(1) : cnt_v;
    end
  end

  generate
    if (TMR != 0) begin : g_tmr
      vote #(.W(W)) u_vote (.a(cnt_r[0]), .b(cnt_r[1]), .c(cnt_r[2]), .y(cnt_v));
    end else begin : g_simplex
      assign cnt_v = cnt_r[0];
    end
  endgenerate

  assign tc = (cnt_v == W'(LIMIT));

endmodule

// File: rtl/vote.sv
// vote: bitwise 2-of-3 majority.
//   a, b, c : the three redundant copies
//   y       : majority value
module vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/fifo1_rd_sched.sv
// fifo1_rd_sched: read-side scheduler for the LCT/L1A block-number FIFO.
// Waits for EMPT_B to stay high SETTLE cycles, latches the head entry, pops it
// once, then either runs the digitizer (START/DONE with timeout) or, for
// SCA-full entries, emits a no-data strobe. GAP idle cycles follow each event.
//   CLK, RST                 : clock, synchronous active-high reset
//   ENABLE                   : allow new events to start
//   EMPT_B, FIFO_*           : fifo1 status and head entry
//   POP                      : one-cycle fifo1 read strobe
//   DIG_START/DIG_BLK/DIG_PHASE/DIG_DONE : digitizer handshake
//   NOSCA_EVT                : event popped with SCA-full set
//   RD_ACTIVE                : not in IDLE
//   EVT_CNT                  : completed events (wraps)
//   TMO_ERR                  : sticky digitizer-timeout flag
module fifo1_rd_sched
  import fifo1_rd_pkg::*;
#(
  parameter int SETTLE  = DEF_SETTLE,
  parameter int GAP     = DEF_GAP,
  parameter int TMO_W   = DEF_TMO_W,
  parameter int TMO_MAX = DEF_TMO_MAX,
  parameter int TMR     = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        EMPT_B,
  input  logic [3:0]  FIFO_DOUT,
  input  logic        FIFO_LCT_PHASE,
  input  logic        FIFO_DLSCAFULL,
  output logic        POP,
  output logic        DIG_START,
  output logic [3:0]  DIG_BLK,
  output logic        DIG_PHASE,
  input  logic        DIG_DONE,
  output logic        NOSCA_EVT,
  output logic        RD_ACTIVE,
  output logic [11:0] EVT_CNT,
  output logic        TMO_ERR
);

  localparam int         N        = (TMR != 0) ? 3 : 1;
  localparam logic [2:0] SETTLE_C = 3'(SETTLE);
  localparam logic [2:0] GAP_C    = 3'(GAP);
  localparam state_t     POST_EVT = (GAP == 0) ? ST_IDLE : ST_GAP;

  core_t core_r [N];
  core_t core_v;
  core_t core_n;
  logic  tmo_tc;
  logic  tmo_hit;

  always_ff @(posedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (RST) core_r[i] <= CORE_RST;
      else     core_r[i] <= core_n;
    end
  end

  generate
    if (TMR != 0) begin : g_tmr
      vote #(.W($bits(core_t))) u_vote (
        .a(core_r[0]), .b(core_r[1]), .c(core_r[2]), .y(core_v)
      );
    end else begin : g_simplex
      assign core_v = core_r[0];
    end
  endgenerate

  // tc fires in the TMO_MAX-th RUN cycle: the counter holds the number of
  // RUN cycles already spent, cleared in START.
  tmo_cnt #(.W(TMO_W), .LIMIT(TMO_MAX - 1), .TMR(TMR)) u_tmo (
    .clk(CLK),
    .rst(RST),
    .clr(core_v.st == ST_START),
    .inc(core_v.st == ST_RUN),
    .tc (tmo_tc)
  );

  always_comb begin
    core_n  = core_v;
    tmo_hit = 1'b0;
    case (core_v.st)
      ST_IDLE: begin
        if (ENABLE && EMPT_B) begin
          core_n.st = ST_SETTLE;
          core_n.sg = 3'd1;
        end
      end
      ST_SETTLE: begin
        // EMPT_B must stay high for the whole window, otherwise start over.
        if (!EMPT_B)                  core_n.st = ST_IDLE;
        else if (core_v.sg == SETTLE_C) core_n.st = ST_LATCH;
        else                          core_n.sg = core_v.sg + 3'd1;
      end
      ST_LATCH: begin
        // The SCA-full flag is consumed here; the branch taken is its record.
        core_n.st = FIFO_DLSCAFULL ? ST_NOSCA : ST_START;
      end
      ST_START: core_n.st = ST_RUN;
      ST_RUN: begin
        // DONE wins over a simultaneous timeout.
        if (DIG_DONE || tmo_tc) begin
          tmo_hit    = !DIG_DONE;
          core_n.evt = core_v.evt + 12'd1;
          core_n.st  = POST_EVT;
          core_n.sg  = 3'd1;
        end
      end
      ST_NOSCA: begin
        core_n.evt = core_v.evt + 12'd1;
        core_n.st  = POST_EVT;
        core_n.sg  = 3'd1;
      end
      ST_GAP: begin
        if (core_v.sg == GAP_C) core_n.st = ST_IDLE;
        else                    core_n.sg = core_v.sg + 3'd1;
      end
      default: core_n.st = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DIG_BLK   <= 4'd0;
      DIG_PHASE <= 1'b0;
      TMO_ERR   <= 1'b0;
    end else begin
      if (core_v.st == ST_LATCH) begin
        DIG_BLK   <= FIFO_DOUT;
        DIG_PHASE <= FIFO_LCT_PHASE;
      end
      if (tmo_hit) TMO_ERR <= 1'b1;
    end
  end

  assign POP       = (core_v.st == ST_LATCH);
  assign DIG_START = (core_v.st == ST_START);
  assign NOSCA_EVT = (core_v.st == ST_NOSCA);
  assign RD_ACTIVE = (core_v.st != ST_IDLE);
  assign EVT_CNT   = core_v.evt;

endmodule

// File: tb/tb_fifo1_rd_sched.sv
// tb_fifo1_rd_sched: scenario tasks around a behavioural fifo1 and digitizer.
// Written entries are pushed to a scoreboard; each DIG_START / NOSCA_EVT pops
// and compares the latched block, phase and SCA-full routing.
module tb_fifo1_rd_sched;

  localparam int SETTLE  = 2;
  localparam int GAP     = 2;
  localparam int TMO_MAX = 20;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b1;
  logic        EMPT_B = 1'b0;
  logic [3:0]  FIFO_DOUT = 4'd0;
  logic        FIFO_LCT_PHASE = 1'b0;
  logic        FIFO_DLSCAFULL = 1'b0;
  logic        DIG_DONE = 1'b0;
  logic        POP, DIG_START, DIG_PHASE, NOSCA_EVT, RD_ACTIVE, TMO_ERR;
  logic [3:0]  DIG_BLK;
  logic [11:0] EVT_CNT;

  fifo1_rd_sched #(.SETTLE(SETTLE), .GAP(GAP), .TMO_W(10), .TMO_MAX(TMO_MAX), .TMR(0)) dut (
    .CLK(clk), .RST(RST), .ENABLE(ENABLE), .EMPT_B(EMPT_B),
    .FIFO_DOUT(FIFO_DOUT), .FIFO_LCT_PHASE(FIFO_LCT_PHASE), .FIFO_DLSCAFULL(FIFO_DLSCAFULL),
    .POP(POP), .DIG_START(DIG_START), .DIG_BLK(DIG_BLK), .DIG_PHASE(DIG_PHASE),
    .DIG_DONE(DIG_DONE), .NOSCA_EVT(NOSCA_EVT), .RD_ACTIVE(RD_ACTIVE),
    .EVT_CNT(EVT_CNT), .TMO_ERR(TMO_ERR)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] blk;
    logic       ph;
    logic       full;
  } ent_t;

  ent_t fifo_q[$];
  ent_t exp_q[$];
  ent_t wr_ent = '0;
  logic wr_en = 1'b0;

  // fifo1 model: registered status and head, reset with the scheduler.
  always @(posedge clk) begin
    if (RST) fifo_q.delete();
    else begin
      if (POP && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (wr_en) fifo_q.push_back(wr_ent);
    end
    EMPT_B <= (fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      FIFO_DOUT      <= fifo_q[0].blk;
      FIFO_LCT_PHASE <= fifo_q[0].ph;
      FIFO_DLSCAFULL <= fifo_q[0].full;
    end else begin
      FIFO_DOUT      <= 4'd0;
      FIFO_LCT_PHASE <= 1'b0;
      FIFO_DLSCAFULL <= 1'b0;
    end
  end

  int checks = 0, errors = 0;
  int cyc = 0, pop_cnt = 0, start_cnt = 0, nosca_cnt = 0;
  int last_pop = -1, start_cyc = -1, nosca_cyc = -1, end_cyc = 0;
  bit have_end = 1'b0;
  logic [11:0] prev_evt = 12'd0;
  int done_dly = 0, done_cnt = 0;

  // One clock: sample outputs just after the falling edge, run the scoreboard
  // and digitizer responder; inputs set by the caller afterwards apply to the
  // current cycle.
  task automatic tick();
    ent_t e;
    @(negedge clk);
    #1;
    cyc++;
    DIG_DONE = 1'b0;
    if (!RST) begin
      if (POP) begin
        pop_cnt++;
        last_pop = cyc;
        checks++;
        if (EMPT_B !== 1'b1) begin
          errors++; $display("FAIL pop_nonempty cyc=%0d EMPT_B=%b expected 1", cyc, EMPT_B);
        end
        if (have_end) begin
          checks++;
          if (cyc - end_cyc < SETTLE + GAP) begin
            errors++; $display("FAIL pop_spacing got %0d cycles expected >= %0d", cyc - end_cyc, SETTLE + GAP);
          end
        end
      end
      if (DIG_START) begin
        start_cnt++;
        start_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL start_unexpected cyc=%0d blk=%0d", cyc, DIG_BLK);
        end else begin
          e = exp_q.pop_front();
          if ({DIG_BLK, DIG_PHASE, 1'b0} !== {e.blk, e.ph, e.full}) begin
            errors++; $display("FAIL start_entry got blk=%0d ph=%b full=0 expected blk=%0d ph=%b full=%b",
                               DIG_BLK, DIG_PHASE, e.blk, e.ph, e.full);
          end
        end
        if (done_dly > 0) done_cnt = done_dly;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) DIG_DONE = 1'b1;
      end
      if (NOSCA_EVT) begin
        nosca_cnt++;
        nosca_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL nosca_unexpected cyc=%0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({DIG_BLK, 1'b1} !== {e.blk, e.full}) begin
            errors++; $display("FAIL nosca_entry got blk=%0d full=1 expected blk=%0d full=%b", DIG_BLK, e.blk, e.full);
          end
        end
      end
      if (EVT_CNT !== prev_evt) begin
        prev_evt = EVT_CNT;
        end_cyc  = cyc;
        have_end = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; ENABLE = 1'b1; wr_en = 1'b0; done_dly = 0; done_cnt = 0;
    tick(); tick();
    RST = 1'b0;
    exp_q.delete();
    have_end = 1'b0;
    prev_evt = 12'd0;
  endtask

  task automatic write_entry(input logic [3:0] b, input logic p, input logic f);
    wr_ent = '{blk: b, ph: p, full: f};
    wr_en  = 1'b1;
    exp_q.push_back(wr_ent);
    tick();
    wr_en  = 1'b0;
  endtask

  task automatic run_until_evt(input logic [11:0] n, input int max);
    for (int i = 0; i < max && EVT_CNT !== n; i++) tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({POP, DIG_START, NOSCA_EVT, RD_ACTIVE, DIG_BLK, DIG_PHASE, TMO_ERR} !== 10'd0) begin
      errors++; $display("FAIL reset_outputs got %b expected 0",
                         {POP, DIG_START, NOSCA_EVT, RD_ACTIVE, DIG_BLK, DIG_PHASE, TMO_ERR});
    end
    checks++;
    if (EVT_CNT !== 12'd0) begin errors++; $display("FAIL reset_evt_cnt got %0d expected 0", EVT_CNT); end
    RST = 1'b0;
  endtask

  task automatic test_single();
    int t0, p0;
    do_reset();
    done_dly = 5;
    t0 = cyc; p0 = pop_cnt;
    write_entry(4'd5, 1'b1, 1'b0);
    while (cyc < t0 + 5) tick();
    checks++;
    if ({DIG_START, DIG_BLK, DIG_PHASE} !== {1'b1, 4'd5, 1'b1}) begin
      errors++; $display("FAIL single_start got start=%b blk=%0d ph=%b expected 1/5/1", DIG_START, DIG_BLK, DIG_PHASE);
    end
    checks++;
    if (last_pop !== t0 + 4 || pop_cnt - p0 !== 1) begin
      errors++; $display("FAIL single_pop got cyc=%0d n=%0d expected cyc=%0d n=1", last_pop - t0, pop_cnt - p0, 4);
    end
    while (cyc < t0 + 10) tick();
    checks++;
    if (EVT_CNT !== 12'd0) begin errors++; $display("FAIL single_evt_early got %0d expected 0", EVT_CNT); end
    tick();
    checks++;
    if (EVT_CNT !== 12'd1) begin errors++; $display("FAIL single_evt got %0d expected 1", EVT_CNT); end
    tick();
    checks++;
    if (RD_ACTIVE !== 1'b1) begin errors++; $display("FAIL single_active_gap got %b expected 1", RD_ACTIVE); end
    tick();
    checks++;
    if (RD_ACTIVE !== 1'b0) begin errors++; $display("FAIL single_idle got %b expected 0", RD_ACTIVE); end
  endtask

  task automatic test_nosca();
    int t0, p0, s0, n0;
    do_reset();
    t0 = cyc; p0 = pop_cnt; s0 = start_cnt; n0 = nosca_cnt;
    write_entry(4'd9, 1'b0, 1'b1);
    while (cyc < t0 + 12) tick();
    checks++;
    if (pop_cnt - p0 !== 1 || last_pop !== t0 + 4) begin
      errors++; $display("FAIL nosca_pop got n=%0d cyc=%0d expected n=1 cyc=4", pop_cnt - p0, last_pop - t0);
    end
    checks++;
    if (nosca_cnt - n0 !== 1 || nosca_cyc !== t0 + 5) begin
      errors++; $display("FAIL nosca_strobe got n=%0d cyc=%0d expected n=1 cyc=5", nosca_cnt - n0, nosca_cyc - t0);
    end
    checks++;
    if (start_cnt - s0 !== 0) begin errors++; $display("FAIL nosca_no_start got %0d expected 0", start_cnt - s0); end
    checks++;
    if ({EVT_CNT, RD_ACTIVE} !== {12'd1, 1'b0}) begin
      errors++; $display("FAIL nosca_evt got cnt=%0d active=%b expected 1/0", EVT_CNT, RD_ACTIVE);
    end
  endtask

  task automatic test_back_to_back();
    int p0, s0;
    do_reset();
    done_dly = 4;
    p0 = pop_cnt; s0 = start_cnt;
    write_entry(4'd3, 1'b0, 1'b0);
    write_entry(4'd7, 1'b1, 1'b0);
    write_entry(4'd12, 1'b0, 1'b0);
    run_until_evt(12'd3, 200);
    repeat (4) tick();
    checks++;
    if (EVT_CNT !== 12'd3) begin errors++; $display("FAIL b2b_evt got %0d expected 3", EVT_CNT); end
    checks++;
    if (pop_cnt - p0 !== 3 || start_cnt - s0 !== 3) begin
      errors++; $display("FAIL b2b_counts got pops=%0d starts=%0d expected 3/3", pop_cnt - p0, start_cnt - s0);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int t0, s, s0;
    do_reset();
    // DONE in the TMO_MAX-th RUN cycle is a normal completion.
    done_dly = TMO_MAX;
    t0 = cyc;
    write_entry(4'd4, 1'b0, 1'b0);
    while (cyc < t0 + 5) tick();
    s = cyc;
    while (cyc < s + TMO_MAX + 1) tick();
    checks++;
    if ({EVT_CNT, TMO_ERR} !== {12'd1, 1'b0}) begin
      errors++; $display("FAIL tmo_boundary got cnt=%0d err=%b expected 1/0", EVT_CNT, TMO_ERR);
    end
    // No DONE at all: abort after TMO_MAX RUN cycles.
    done_dly = 0;
    write_entry(4'd6, 1'b1, 1'b0);
    for (int i = 0; i < 40 && DIG_START !== 1'b1; i++) tick();
    checks++;
    if (DIG_START !== 1'b1) begin errors++; $display("FAIL tmo_second_start got %b expected 1", DIG_START); end
    s = cyc;
    while (cyc < s + TMO_MAX) tick();
    checks++;
    if (TMO_ERR !== 1'b0) begin errors++; $display("FAIL tmo_early got %b expected 0", TMO_ERR); end
    tick();
    checks++;
    if ({EVT_CNT, TMO_ERR} !== {12'd2, 1'b1}) begin
      errors++; $display("FAIL tmo_abort got cnt=%0d err=%b expected 2/1", EVT_CNT, TMO_ERR);
    end
    s0 = start_cnt;
    done_dly = 3;
    write_entry(4'd11, 1'b0, 1'b0);
    run_until_evt(12'd3, 100);
    checks++;
    if ({EVT_CNT, TMO_ERR} !== {12'd3, 1'b1} || start_cnt - s0 !== 1) begin
      errors++; $display("FAIL tmo_after got cnt=%0d err=%b starts=%0d expected 3/1/1", EVT_CNT, TMO_ERR, start_cnt - s0);
    end
  endtask

  task automatic test_rst_mid();
    int t0, p0, s0;
    do_reset();
    t0 = cyc;
    write_entry(4'd2, 1'b1, 1'b0);
    while (cyc < t0 + 7) tick();
    checks++;
    if (RD_ACTIVE !== 1'b1) begin errors++; $display("FAIL rst_mid_running got %b expected 1", RD_ACTIVE); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_q.delete();
    checks++;
    if ({POP, DIG_START, NOSCA_EVT, RD_ACTIVE, DIG_BLK, DIG_PHASE, TMO_ERR, EVT_CNT} !== 22'd0) begin
      errors++; $display("FAIL rst_mid_outputs got %b evt=%0d expected 0",
                         {POP, DIG_START, NOSCA_EVT, RD_ACTIVE, DIG_BLK, DIG_PHASE, TMO_ERR}, EVT_CNT);
    end
    p0 = pop_cnt; s0 = start_cnt;
    repeat (30) tick();
    checks++;
    if (pop_cnt - p0 !== 0 || start_cnt - s0 !== 0) begin
      errors++; $display("FAIL rst_mid_quiet got pops=%0d starts=%0d expected 0/0", pop_cnt - p0, start_cnt - s0);
    end
    done_dly = 3;
    write_entry(4'd8, 1'b0, 1'b0);
    run_until_evt(12'd1, 60);
    checks++;
    if (EVT_CNT !== 12'd1 || start_cnt - s0 !== 1) begin
      errors++; $display("FAIL rst_mid_resume got cnt=%0d starts=%0d expected 1/1", EVT_CNT, start_cnt - s0);
    end
  endtask

  task automatic test_enable();
    int p0, e;
    do_reset();
    ENABLE = 1'b0;
    write_entry(4'd1, 1'b0, 1'b0);
    write_entry(4'd10, 1'b1, 1'b0);
    p0 = pop_cnt;
    repeat (50) tick();
    checks++;
    if (pop_cnt - p0 !== 0 || RD_ACTIVE !== 1'b0) begin
      errors++; $display("FAIL en_hold got pops=%0d active=%b expected 0/0", pop_cnt - p0, RD_ACTIVE);
    end
    e = cyc;
    ENABLE = 1'b1;
    done_dly = 6;
    while (cyc < e + 6) tick();
    checks++;
    if (last_pop !== e + SETTLE + 1) begin
      errors++; $display("FAIL en_pop_latency got %0d expected %0d", last_pop - e, SETTLE + 1);
    end
    ENABLE = 1'b0;
    repeat (40) tick();
    checks++;
    if ({EVT_CNT, RD_ACTIVE, EMPT_B} !== {12'd1, 1'b0, 1'b1} || pop_cnt - p0 !== 1) begin
      errors++; $display("FAIL en_stop got cnt=%0d active=%b empt_b=%b pops=%0d expected 1/0/1/1",
                         EVT_CNT, RD_ACTIVE, EMPT_B, pop_cnt - p0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_nosca();
    test_back_to_back();
    test_timeout();
    test_rst_mid();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
